// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer: streams multi-word add/subtract through one shared 32-bit adder.
// Operand words are read least-significant first from a dual-read RAM. Each word
// is summed in the cycle after its read and written back, with the inter-word
// carry held in a register.
// Optional feature macro: MP_ADD_SUB_EN (subtract support). When it is undefined,
// the design is add-only and has no inverters on the B path.
module mp_add_sequencer #(
    parameter int WORDS = 32,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          sub,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          carry_out,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_a,
    input  logic [31:0]   rd_b,
    output logic [31:0]   add_a,
    output logic [31:0]   add_b,
    output logic          add_cin,
    input  logic [31:0]   add_s,
    input  logic          add_cout,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data
);

`ifdef MP_ADD_SUB_EN
    localparam logic SUB_EN = 1'b1;
`else
    localparam logic SUB_EN = 1'b0;
`endif

    localparam logic [AW:0] MAX_N = WORDS[AW:0];

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t      state;
    logic [AW:0] n_q;
    logic        sub_q;
    logic        carry_q;
    logic [AW:0] n_in;

    // Clamp the requested length to the RAM depth.
    assign n_in = (len > MAX_N) ? MAX_N : len;

    // Control FSM. The read and write pointers and the carry register are kept here too.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            n_q       <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            carry_out <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
        end else begin
            done  <= 1'b0;
            // Read data arrives one cycle after the strobe, so the write trails the read.
            wr_en <= rd_en;
            if (wr_en) begin
                carry_q <= add_cout;
                wr_addr <= wr_addr + AW'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        // A subtract is ~B + 1, so the carry register is preloaded with sub.
                        sub_q     <= SUB_EN & sub;
                        carry_q   <= SUB_EN & sub;
                        n_q       <= n_in;
                        rd_addr   <= '0;
                        wr_addr   <= '0;
                        carry_out <= 1'b0;
                        busy      <= 1'b1;
                        if (n_in == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            rd_en <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if ({1'b0, rd_addr} == n_q - (AW+1)'(1)) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    // The last word is being written now. Its adder carry-out is the final
                    // carry. A subtract reports borrow, which is the inverted carry.
                    state     <= FINISH;
                    done      <= 1'b1;
                    carry_out <= sub_q ^ add_cout;
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Adder operands and write data are live only during a write cycle. They are zero otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        wr_data = '0;
        if (wr_en) begin
            add_a   = rd_a;
`ifdef MP_ADD_SUB_EN
            add_b   = sub_q ? ~rd_b : rd_b;
`else
            add_b   = rd_b;
`endif
            add_cin = carry_q;
            wr_data = add_s;
        end
    end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Testbench for mp_add_sequencer. It models the operand RAM and the adder, and it
// uses a write scoreboard. The expected words come from whole-vector arithmetic.
module tb_mp_add_sequencer;
    localparam int WORDS = 8;
    localparam int AW    = $clog2(WORDS);
    localparam int VW    = WORDS * 32;

    logic          CLK, RST, start, sub;
    logic [AW:0]   len;
    logic          busy, done, carry_out, rd_en, wr_en, add_cin, add_cout;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [31:0]   rd_a, rd_b, add_a, add_b, add_s, wr_data;

    mp_add_sequencer #(.WORDS(WORDS), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .sub(sub), .len(len),
        .busy(busy), .done(done), .carry_out(carry_out),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External 32-bit adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    // Operand RAM, one-cycle read latency
    logic [31:0] mem_a [WORDS];
    logic [31:0] mem_b [WORDS];
    always @(posedge CLK) if (rd_en) begin
        rd_a <= mem_a[rd_addr];
        rd_b <= mem_b[rd_addr];
    end

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int written_max = -1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result RAM write tracking
    always @(posedge CLK) if (wr_en && int'(wr_addr) > written_max) written_max = int'(wr_addr);

    // Write and read monitor, sampled away from the active edge
    always @(negedge CLK) begin
        if (!RST) begin
            if (wr_en) begin
                if (sb_q.size() == 0) chk("write_expected", 64'(sb_q.size() != 0), 64'd1);
                else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                    chk("wr_data", 64'(wr_data), 64'(e.data));
                end
            end else begin
                chk("adder_idle", 64'(add_a | add_b | {31'd0, add_cin}), 64'd0);
            end
            if (rd_en) begin
                chk("rd_addr", 64'(rd_addr), 64'(rd_cnt));
                rd_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference arithmetic over the whole n-word vector
    task automatic model(input logic [VW-1:0] a, input logic [VW-1:0] b, input bit s, input int n,
                         output logic [VW:0] r, output bit c);
        logic [VW:0] one, mask, av, bv;
        one  = 1;
        mask = (one << (32 * n)) - one;
        av   = {1'b0, a} & mask;
        bv   = {1'b0, b} & mask;
        if (s) begin
            r = (av - bv) & mask;
            c = (av < bv);
        end else begin
            r = av + bv;
            c = r[32 * n];
        end
    endtask

    task automatic load(input logic [VW-1:0] a, input logic [VW-1:0] b);
        for (int i = 0; i < WORDS; i++) begin
            mem_a[i] = a[32*i +: 32];
            mem_b[i] = b[32*i +: 32];
        end
    endtask

    task automatic push_words(input logic [VW:0] r, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            wr_t e;
            e.addr = AW'(i);
            e.data = r[32*i +: 32];
            sb_q.push_back(e);
        end
    endtask

    // Run one operation. pulse_at >= 0 drives a stray start during the run.
    task automatic run_op(input string tag, input bit s, input int len_i,
                          input logic [VW-1:0] a, input logic [VW-1:0] b, input int pulse_at);
        int n, k, lat;
        bit s_eff, c;
        logic [VW:0] r;
        n = (len_i > WORDS) ? WORDS : len_i;
`ifdef MP_ADD_SUB_EN
        s_eff = s;
`else
        s_eff = 1'b0;
`endif
        model(a, b, s_eff, n, r, c);
        load(a, b);
        push_words(r, n);
        rd_cnt = 0;
        start = 1'b1; sub = s; len = (AW+1)'(len_i);
        tick();
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            chk({tag, " busy_run"}, 64'(busy), 64'd1);
            start = (k == pulse_at);
            tick();
            k++;
        end
        start = 1'b0;
        lat = (n == 0) ? 0 : n + 1;
        chk({tag, " done_lat"}, 64'(k), 64'(lat));
        chk({tag, " busy_done"}, 64'(busy), 64'd1);
        chk({tag, " carry_out"}, 64'(carry_out), 64'(c));
        chk({tag, " writes_left"}, 64'(sb_q.size()), 64'd0);
        chk({tag, " reads"}, 64'(rd_cnt), 64'(n));
        tick();
        chk({tag, " idle"}, {62'd0, busy, done}, 64'd0);
        chk({tag, " carry_held"}, 64'(carry_out), 64'(c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [VW-1:0] a, b;
        logic [VW:0]   r;
        bit            c;
        start = 1'b0; sub = 1'b0; len = '0; RST = 1'b0;
        #1 RST = 1'b1;
        tick();
        chk("reset_ctl", {58'd0, busy, done, carry_out, rd_en, wr_en, add_cin}, 64'd0);
        chk("reset_addr", 64'({rd_addr, wr_addr}), 64'd0);
        chk("reset_data", {wr_data, add_a | add_b}, 64'd0);
        RST = 1'b0;
        tick();

        run_op("add1", 1'b0, 1, VW'(32'hFFFF_FFFF), VW'(32'h1), -1);
        run_op("add4_ripple", 1'b0, 4, '1, VW'(1), -1);
        run_op("sub_5_7", 1'b1, 2, VW'(5), VW'(7), -1);
        run_op("sub_7_5", 1'b1, 2, VW'(7), VW'(5), -1);
        run_op("len0", 1'b0, 0, VW'(3), VW'(4), -1);
        for (int i = 0; i < WORDS; i++) begin
            a[32*i +: 32] = $urandom;
            b[32*i +: 32] = $urandom;
        end
        run_op("len_over", 1'b0, WORDS + 5, a, b, -1);
        run_op("stray_start", 1'b1, 8, b, a, 1);
        run_op("back_to_back", 1'b0, 3, a, b, -1);

        // Reset in the middle of a len=8 run. Only words 0 and 1 complete.
        model(a, b, 1'b0, 8, r, c);
        load(a, b);
        push_words(r, 2);
        rd_cnt = 0;
        written_max = -1;
        start = 1'b1; sub = 1'b0; len = (AW+1)'(8);
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #1 RST = 1'b1;
        #1;
        chk("rst_async_ctl", {58'd0, busy, done, carry_out, rd_en, wr_en, add_cin}, 64'd0);
        chk("rst_async_addr", 64'({rd_addr, wr_addr}), 64'd0);
        chk("rst_async_data", {wr_data, add_a | add_b}, 64'd0);
        tick(); tick();
        RST = 1'b0;
        tick(); tick();
        chk("rst_no_late_write", 64'(written_max <= 2), 64'd1);
        chk("rst_writes_done", 64'(sb_q.size()), 64'd0);
        run_op("after_rst", 1'b1, 3, b, a, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
